// File: rtl/apb_arb_master.sv
// apb_arb_master: two-requester APB master with round-robin arbitration.
//   PCLK, PRESET            : clock, synchronous active-high reset
//   req_valid/write/addr/wdata : per-requester request (requester i in slice i)
//   req_ack                 : one-cycle pulse in the SETUP cycle of the granted requester
//   rsp_valid/rdata/err     : one-cycle completion pulse, read data, timeout flag
//   busy                    : FSM not in IDLE
//   PADDR/PWDATA/PWRITE/PSEL/PENABLE, PRDATA/PREADY : APB master port
module apb_arb_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [1:0]  req_ack,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic        PSEL,
  output logic        PENABLE,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_d;
  logic        ptr, ptr_d;
  logic        gnt, gnt_d;
  logic [7:0]  wait_cnt, wait_cnt_d;
  logic [31:0] paddr_d, pwdata_d, rdata_d;
  logic        pwrite_d, psel_d, penable_d, err_d;
  logic [1:0]  ack_d, rv_d;

  logic [1:0][31:0] addr_v, wdata_v;
  logic             pick;

  assign addr_v  = req_addr;
  assign wdata_v = req_wdata;

  // Both valid: pointer decides. Otherwise the lone valid requester wins
  // (req_valid[1] is 1 exactly when requester 1 is the only one).
  assign pick = (&req_valid) ? ptr : req_valid[1];

  always_comb begin
    state_d    = state;
    ptr_d      = ptr;
    gnt_d      = gnt;
    wait_cnt_d = wait_cnt;
    paddr_d    = PADDR;
    pwdata_d   = PWDATA;
    pwrite_d   = PWRITE;
    psel_d     = PSEL;
    penable_d  = PENABLE;
    rdata_d    = rsp_rdata;
    err_d      = rsp_err;
    ack_d      = '0;
    rv_d       = '0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          state_d     = SETUP;
          gnt_d       = pick;
          ptr_d       = ~pick;
          wait_cnt_d  = '0;
          paddr_d     = addr_v[pick];
          pwdata_d    = wdata_v[pick];
          pwrite_d    = req_write[pick];
          psel_d      = 1'b1;
          penable_d   = 1'b0;
          ack_d[pick] = 1'b1;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        // PREADY is checked first so a ready in the last allowed cycle
        // still completes normally.
        if (PREADY) begin
          state_d    = IDLE;
          psel_d     = 1'b0;
          penable_d  = 1'b0;
          rv_d[gnt]  = 1'b1;
          err_d      = 1'b0;
          rdata_d    = PWRITE ? 32'h0 : PRDATA;
        end else if (wait_cnt == TO_LAST) begin
          state_d    = IDLE;
          psel_d     = 1'b0;
          penable_d  = 1'b0;
          rv_d[gnt]  = 1'b1;
          err_d      = 1'b1;
          rdata_d    = 32'h0;
        end else begin
          wait_cnt_d = wait_cnt + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      gnt       <= 1'b0;
      wait_cnt  <= '0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PWRITE    <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      req_ack   <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      gnt       <= gnt_d;
      wait_cnt  <= wait_cnt_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
      PWRITE    <= pwrite_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      req_ack   <= ack_d;
      rsp_valid <= rv_d;
      rsp_rdata <= rdata_d;
      rsp_err   <= err_d;
      busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_apb_arb_master.sv
// Table-driven bench for apb_arb_master (TIMEOUT_CYCLES=4). Each row gives
// inputs applied before a rising edge and the outputs expected after it.
module tb_apb_arb_master;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [1:0]  req_valid, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_ack, rsp_valid;
  logic [31:0] rsp_rdata, PADDR, PWDATA, PRDATA;
  logic        rsp_err, busy, PWRITE, PSEL, PENABLE, PREADY;

  apb_arb_master #(.TIMEOUT_CYCLES(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        rst;
    logic [1:0]  v, w;
    logic        rdy;
    logic [31:0] prd;
    logic        psel, pen;
    logic [1:0]  ack, rv;
    logic [31:0] rdata;
    logic        err, busy, pwrite;
    logic [31:0] paddr, pwdata;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  localparam logic [31:0] A  = 32'h10;
  localparam logic [31:0] D  = 32'hDEADBEEF;
  localparam logic [31:0] B  = 32'h0BADF00D;
  localparam logic [31:0] FF = 32'hFFFFFFFF;

  task automatic add(input logic rst, input logic [1:0] v, input logic [1:0] w,
                     input logic rdy, input logic [31:0] prd,
                     input logic psel, input logic pen, input logic [1:0] ack,
                     input logic [1:0] rv, input logic [31:0] rdata, input logic err,
                     input logic bsy, input logic pwrite, input logic [31:0] paddr,
                     input logic [31:0] pwdata);
    vec_t r;
    r.rst = rst; r.v = v; r.w = w; r.rdy = rdy; r.prd = prd;
    r.psel = psel; r.pen = pen; r.ack = ack; r.rv = rv; r.rdata = rdata;
    r.err = err; r.busy = bsy; r.pwrite = pwrite; r.paddr = paddr; r.pwdata = pwdata;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    int pcnt;
    bit seen;
    logic [1:0]  s_rv;
    logic [31:0] s_rd;
    logic        s_er;

    PRESET = 1'b1; req_valid = '0; req_write = '0; PREADY = 1'b0; PRDATA = '0;
    req_addr  = {A, A};
    req_wdata = {B, D};

    //   rst v  w  rdy prd        psel pen ack rv rdata       err bsy pw  paddr pwdata
    add(1, 0, 0, 0, 0,          0, 0, 0, 0, 0,          0, 0, 0, 0, 0);  // reset
    // single write by requester 0, PREADY on 2nd ACCESS
    add(0, 1, 1, 0, 0,          1, 0, 1, 0, 0,          0, 1, 1, A, D);
    add(0, 0, 1, 0, 0,          1, 1, 0, 0, 0,          0, 1, 1, A, D);
    add(0, 0, 1, 0, 0,          1, 1, 0, 0, 0,          0, 1, 1, A, D);
    add(0, 0, 1, 1, FF,         0, 0, 0, 1, 0,          0, 0, 1, A, D);
    // readback by requester 1
    add(0, 2, 0, 0, 0,          1, 0, 2, 0, 0,          0, 1, 0, A, B);
    add(0, 0, 0, 0, 0,          1, 1, 0, 0, 0,          0, 1, 0, A, B);
    add(0, 0, 0, 1, D,          0, 0, 0, 2, D,          0, 0, 0, A, B);
    add(0, 0, 0, 0, 0,          0, 0, 0, 0, D,          0, 0, 0, A, B);
    // timeout: 4 ACCESS cycles, PREADY stuck low
    add(0, 1, 0, 0, 0,          1, 0, 1, 0, D,          0, 1, 0, A, D);
    add(0, 0, 0, 0, 0,          1, 1, 0, 0, D,          0, 1, 0, A, D);
    add(0, 0, 0, 0, 0,          1, 1, 0, 0, D,          0, 1, 0, A, D);
    add(0, 0, 0, 0, 0,          1, 1, 0, 0, D,          0, 1, 0, A, D);
    add(0, 0, 0, 0, 0,          1, 1, 0, 0, D,          0, 1, 0, A, D);
    add(0, 0, 0, 0, FF,         0, 0, 0, 1, 0,          1, 0, 0, A, D);
    // following write completes normally
    add(0, 2, 2, 0, 0,          1, 0, 2, 0, 0,          1, 1, 1, A, B);
    add(0, 0, 2, 0, 0,          1, 1, 0, 0, 0,          1, 1, 1, A, B);
    add(0, 0, 2, 1, FF,         0, 0, 0, 2, 0,          0, 0, 1, A, B);
    // collision: PREADY on the 4th ACCESS cycle
    add(0, 1, 0, 0, 0,          1, 0, 1, 0, 0,          0, 1, 0, A, D);
    add(0, 0, 0, 0, 0,          1, 1, 0, 0, 0,          0, 1, 0, A, D);
    add(0, 0, 0, 0, 0,          1, 1, 0, 0, 0,          0, 1, 0, A, D);
    add(0, 0, 0, 0, 0,          1, 1, 0, 0, 0,          0, 1, 0, A, D);
    add(0, 0, 0, 0, 0,          1, 1, 0, 0, 0,          0, 1, 0, A, D);
    add(0, 0, 0, 1, 32'h12345678, 0, 0, 0, 1, 32'h12345678, 0, 0, 0, A, D);
    // contention from reset: 0,1,0,1
    add(1, 3, 0, 0, 0,          0, 0, 0, 0, 0,          0, 0, 0, 0, 0);
    add(0, 3, 0, 0, 0,          1, 0, 1, 0, 0,          0, 1, 0, A, D);
    add(0, 3, 0, 0, 0,          1, 1, 0, 0, 0,          0, 1, 0, A, D);
    add(0, 3, 0, 1, 32'h11,     0, 0, 0, 1, 32'h11,     0, 0, 0, A, D);
    add(0, 3, 0, 0, 0,          1, 0, 2, 0, 32'h11,     0, 1, 0, A, B);
    add(0, 3, 0, 0, 0,          1, 1, 0, 0, 32'h11,     0, 1, 0, A, B);
    add(0, 3, 0, 1, 32'h22,     0, 0, 0, 2, 32'h22,     0, 0, 0, A, B);
    add(0, 3, 0, 0, 0,          1, 0, 1, 0, 32'h22,     0, 1, 0, A, D);
    add(0, 3, 0, 0, 0,          1, 1, 0, 0, 32'h22,     0, 1, 0, A, D);
    add(0, 3, 0, 1, 32'h33,     0, 0, 0, 1, 32'h33,     0, 0, 0, A, D);
    add(0, 3, 0, 0, 0,          1, 0, 2, 0, 32'h33,     0, 1, 0, A, B);
    add(0, 3, 0, 0, 0,          1, 1, 0, 0, 32'h33,     0, 1, 0, A, B);
    add(0, 3, 0, 1, 32'h44,     0, 0, 0, 2, 32'h44,     0, 0, 0, A, B);
    // mid-transfer reset with pointer at 1; PREADY high during reset
    add(0, 3, 0, 0, 0,          1, 0, 1, 0, 32'h44,     0, 1, 0, A, D);
    add(0, 3, 0, 0, 0,          1, 1, 0, 0, 32'h44,     0, 1, 0, A, D);
    add(1, 3, 0, 1, 32'h99,     0, 0, 0, 0, 0,          0, 0, 0, 0, 0);
    add(0, 3, 0, 0, 0,          1, 0, 1, 0, 0,          0, 1, 0, A, D);
    add(0, 0, 0, 0, 0,          1, 1, 0, 0, 0,          0, 1, 0, A, D);
    add(0, 0, 0, 1, 32'h55,     0, 0, 0, 1, 32'h55,     0, 0, 0, A, D);

    foreach (tbl[i]) begin
      @(negedge PCLK);
      PRESET = tbl[i].rst; req_valid = tbl[i].v; req_write = tbl[i].w;
      PREADY = tbl[i].rdy; PRDATA = tbl[i].prd;
      @(posedge PCLK); #1;
      chk("psel",   i, 32'(PSEL),      32'(tbl[i].psel));
      chk("penable",i, 32'(PENABLE),   32'(tbl[i].pen));
      chk("ack",    i, 32'(req_ack),   32'(tbl[i].ack));
      chk("rvalid", i, 32'(rsp_valid), 32'(tbl[i].rv));
      chk("rdata",  i, rsp_rdata,      tbl[i].rdata);
      chk("err",    i, 32'(rsp_err),   32'(tbl[i].err));
      chk("busy",   i, 32'(busy),      32'(tbl[i].busy));
      chk("pwrite", i, 32'(PWRITE),    32'(tbl[i].pwrite));
      chk("paddr",  i, PADDR,          tbl[i].paddr);
      chk("pwdata", i, PWDATA,         tbl[i].pwdata);
    end

    // Hand sequence: requester 1 read against a dead slave; count PSEL
    // cycles (1 SETUP + 4 ACCESS) and wait a bounded time for the response.
    @(negedge PCLK);
    req_valid = 2'b10; req_write = 2'b00; PREADY = 1'b0; PRDATA = FF;
    pcnt = 0; seen = 0; s_rv = '0; s_rd = '1; s_er = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge PCLK); #1;
      if (req_ack[1]) req_valid = 2'b00;
      if (PSEL) pcnt++;
      if (rsp_valid != 2'b00) begin
        seen = 1; s_rv = rsp_valid; s_rd = rsp_rdata; s_er = rsp_err;
      end
    end
    chk("to_seen",  99, 32'(seen), 32'd1);
    chk("to_rv",    99, 32'(s_rv), 32'd2);
    chk("to_err",   99, 32'(s_er), 32'd1);
    chk("to_rdata", 99, s_rd,      32'h0);
    chk("to_psel_cycles", 99, 32'(pcnt), 32'd5);
    chk("to_busy",  99, 32'(busy), 32'd0);
    @(posedge PCLK); #1;
    chk("to_rv_drop", 100, 32'(rsp_valid), 32'd0);
    chk("to_err_hold", 100, 32'(rsp_err), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
